// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, instruction field positions.
package mips_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_DROP = 2'b11;

    localparam int INSTR_W = 32;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        REQ  = S_REQ,
        HOLD = S_HOLD,
        DROP = S_DROP
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module flopenr #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem req/ack, valid/ready to decode, redirect flush.
// Optional FETCH_STATS_EN adds a saturating memory wait-cycle counter.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic [31:0]        instr_pc4,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        wait_cycles
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_next_q, pc_next_d, target;
    logic         pc_en, fetch_en;

    assign target = word_align(redirect_pc);

    flopenr #(.WIDTH(32), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .en(pc_en), .d(pc_d), .q(pc_q)
    );
    flopenr #(.WIDTH(INSTR_W), .RST_VAL('0)) u_instr (
        .clk(clk), .reset(reset), .en(fetch_en), .d(imem_rdata), .q(instr)
    );
    flopenr #(.WIDTH(32), .RST_VAL(RESET_PC)) u_instr_pc (
        .clk(clk), .reset(reset), .en(fetch_en), .d(pc_q), .q(instr_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_next_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_next_q <= pc_next_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_en     = 1'b0;
        fetch_en  = 1'b0;
        pc_next_d = pc_next_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack && !redirect) begin
                    fetch_en = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    pc_en    = 1'b1;
                    state_d  = HOLD;
                end else if (imem_ack) begin
                    pc_d  = target;
                    pc_en = 1'b1;
                end else if (redirect) begin
                    // pc stays put: the in-flight request's address must not move
                    pc_next_d = target;
                    state_d   = DROP;
                end
            end
            DROP: begin
                if (redirect) pc_next_d = target;
                if (imem_ack) begin
                    pc_d    = redirect ? target : pc_next_q;
                    pc_en   = 1'b1;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    pc_en   = 1'b1;
                    state_d = REQ;
                end else if (instr_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr_pc4   = instr_pc + 32'd4;

`ifdef FETCH_STATS_EN
    logic [31:0] wait_q;

    always_ff @(posedge clk) begin
        if (reset)
            wait_q <= '0;
        else if ((state_q == REQ || state_q == DROP) && !imem_ack && wait_q != 32'hFFFF_FFFF)
            wait_q <= wait_q + 32'd1;
    end

    assign wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, instr_pc4, redirect_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] wait_cycles;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
        , .wait_cycles(wait_cycles)
`endif
    );

    // Memory: ack after `lat` cycles of a request; zero-wait acks combinationally.
    int          lat = 0;
    int          cnt;
    logic        busy;
    logic [31:0] addr_l;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        if (a == 32'h0)  return 32'h8C08_0004;
        if (a == 32'h44) return 32'hDEAD_BEEF;
        return ~a;
    endfunction

    assign imem_ack   = busy ? (cnt == lat) : (imem_req && lat == 0);
    assign imem_rdata = imem_ack ? memdata(busy ? addr_l : imem_addr) : 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= 0;
        end else if (busy) begin
            if (imem_ack) busy <= 1'b0;
            else          cnt  <= cnt + 1;
        end else if (imem_req && !imem_ack) begin
            busy   <= 1'b1;
            cnt    <= 1;
            addr_l <= imem_addr;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; lat = 0;
        tick; tick;
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL reset_req got %b exp 0", imem_req); end
        vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        vecs++; if (instr !== 32'h0) begin errs++; $display("FAIL reset_instr got %h exp 0", instr); end
        vecs++; if (instr_pc4 !== 32'h4) begin errs++; $display("FAIL reset_pc4 got %h exp 4", instr_pc4); end
`ifdef FETCH_STATS_EN
        vecs++; if (wait_cycles !== 32'h0) begin errs++; $display("FAIL reset_wait got %0d exp 0", wait_cycles); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_zero_wait;
        for (int i = 0; i < 3; i++) begin
            tick;
            vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'(i*4)) begin errs++; $display("FAIL zw_req%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, i*4); end
            vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL zw_novalid%0d got %b exp 0", i, instr_valid); end
            if (i == 2) break;
            tick;
            vecs++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errs++; $display("FAIL zw_hold%0d got valid=%b req=%b exp 1/0", i, instr_valid, imem_req); end
            vecs++; if (instr_pc !== 32'(i*4) || instr_pc4 !== 32'(i*4+4)) begin errs++; $display("FAIL zw_pc%0d got %h/%h exp %h/%h", i, instr_pc, instr_pc4, i*4, i*4+4); end
            vecs++; if (instr !== memdata(32'(i*4))) begin errs++; $display("FAIL zw_instr%0d got %h exp %h", i, instr, memdata(32'(i*4))); end
        end
    endtask

    // Enters in REQ at 8 (zero-wait ack pending); first completes it, then waits 3 cycles at 12.
    task automatic test_wait;
        logic [31:0] wc0;
        tick;
        lat = 3;
        wc0 = 32'h0;
`ifdef FETCH_STATS_EN
        wc0 = wait_cycles;
`endif
        for (int i = 0; i < 3; i++) begin
            tick;
            vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || imem_ack !== 1'b0) begin errs++; $display("FAIL wait_stable%0d got req=%b addr=%h ack=%b exp 1/c/0", i, imem_req, imem_addr, imem_ack); end
        end
        tick;
        vecs++; if (imem_ack !== 1'b1 || imem_addr !== 32'hC) begin errs++; $display("FAIL wait_ack got ack=%b addr=%h exp 1/c", imem_ack, imem_addr); end
        tick;
        lat = 0;
        vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr !== memdata(32'hC)) begin errs++; $display("FAIL wait_hold got v=%b pc=%h i=%h", instr_valid, instr_pc, instr); end
`ifdef FETCH_STATS_EN
        vecs++; if (wait_cycles - wc0 !== 32'd3) begin errs++; $display("FAIL wait_count got %0d exp 3", wait_cycles - wc0); end
`else
        if (wc0 != 32'h0) $display("unexpected wc0");
`endif
    endtask

    task automatic test_redirect_hold;
        redirect = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect = 1'b0;
        vecs++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin errs++; $display("FAIL rdh got v=%b req=%b addr=%h exp 0/1/40", instr_valid, imem_req, imem_addr); end
        tick;
        vecs++; if (instr_pc !== 32'h40 || instr_valid !== 1'b1) begin errs++; $display("FAIL rdh_fetch got pc=%h v=%b exp 40/1", instr_pc, instr_valid); end
    endtask

    task automatic test_redirect_req;
        lat = 2;
        tick;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin errs++; $display("FAIL rdr_req got %b/%h exp 1/44", imem_req, imem_addr); end
        redirect = 1'b1; redirect_pc = 32'h80;
        tick;
        redirect = 1'b0;
        vecs++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errs++; $display("FAIL rdr_drop1 got req=%b v=%b exp 0/0", imem_req, instr_valid); end
        tick;
        vecs++; if (imem_ack !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errs++; $display("FAIL rdr_drop2 got ack=%b req=%b v=%b exp 1/0/0", imem_ack, imem_req, instr_valid); end
        tick;
        lat = 0;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || instr_valid !== 1'b0) begin errs++; $display("FAIL rdr_refetch got req=%b addr=%h v=%b exp 1/80/0", imem_req, imem_addr, instr_valid); end
        tick;
        vecs++; if (instr_pc !== 32'h80 || instr !== memdata(32'h80)) begin errs++; $display("FAIL rdr_data got pc=%h i=%h exp 80/%h", instr_pc, instr, memdata(32'h80)); end
    endtask

    task automatic test_stall;
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            vecs++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 32'h80 || instr !== memdata(32'h80)) begin errs++; $display("FAIL stall%0d got v=%b req=%b pc=%h i=%h", i, instr_valid, imem_req, instr_pc, instr); end
        end
        instr_ready = 1'b1;
        tick;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin errs++; $display("FAIL stall_release got %b/%h exp 1/84", imem_req, imem_addr); end
    endtask

    task automatic test_wrap;
        tick;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick;
        redirect = 1'b0;
        vecs++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin errs++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
        tick;
        vecs++; if (instr_pc !== 32'hFFFF_FFFC || instr_pc4 !== 32'h0) begin errs++; $display("FAIL wrap_pc4 got %h/%h exp fffffffc/0", instr_pc, instr_pc4); end
        tick;
        vecs++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errs++; $display("FAIL wrap_next got %h exp 0", imem_addr); end
    endtask

    // Enters in REQ at 0 with zero-wait ack; redirect coincides with the ack.
    task automatic test_ack_redirect;
        redirect = 1'b1; redirect_pc = 32'h300;
        tick;
        redirect = 1'b0;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin errs++; $display("FAIL ackrd got req=%b addr=%h v=%b exp 1/300/0", imem_req, imem_addr, instr_valid); end
        tick;
        vecs++; if (instr_pc !== 32'h300 || instr_valid !== 1'b1) begin errs++; $display("FAIL ackrd_fetch got %h/%b exp 300/1", instr_pc, instr_valid); end
    endtask

    task automatic test_drop_overwrite;
        lat = 2;
        tick;
        redirect = 1'b1; redirect_pc = 32'h100;
        tick;
        redirect = 1'b0;
        tick;
        vecs++; if (imem_ack !== 1'b1 || imem_req !== 1'b0) begin errs++; $display("FAIL ovw_ack got ack=%b req=%b exp 1/0", imem_ack, imem_req); end
        redirect = 1'b1; redirect_pc = 32'h200;
        tick;
        redirect = 1'b0; lat = 0;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errs++; $display("FAIL ovw_addr got %b/%h exp 1/200", imem_req, imem_addr); end
        tick;
        vecs++; if (instr_pc !== 32'h200) begin errs++; $display("FAIL ovw_fetch got %h exp 200", instr_pc); end
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        vecs++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin errs++; $display("FAIL rstmid got v=%b req=%b i=%h pc=%h", instr_valid, imem_req, instr, instr_pc); end
        tick;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL rstmid_req got %b/%h exp 1/0", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_wait;
        test_redirect_hold;
        test_redirect_req;
        test_stall;
        test_wrap;
        test_ack_redirect;
        test_drop_overwrite;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
